execute_cycle: RTL
==================

EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 Parameter: DATA_W, 32, datapath width; only 32 is required to be supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  in  1 each  control signals from the decode stage.
REQ-005 ALUControlE  in  3  ALU operation select.
REQ-006 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  32 each  operands, immediate and PCs from decode.
REQ-007 RD_E  in  5  destination register.
REQ-008 ResultW  in  32  writeback result, used for forwarding.
REQ-009 ForwardA_E, ForwardB_E  in  2 each  forwarding selects from the hazard unit.
REQ-010 PCSrcE  out  1  branch taken (combinational).
REQ-011 PCTargetE  out  32  branch target (combinational).
REQ-012 RegWriteM, MemWriteM, ResultSrcM  out  1 each  registered controls to the memory stage.
REQ-013 RD_M  out  5; ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered data to the memory stage.

Function
REQ-014 SrcA SHALL select RD1_E, ResultW or ALUResultM when ForwardA_E is 00, 01 or 10 respectively; 11 SHALL select RD1_E.
REQ-015 Forwarded B SHALL select RD2_E, ResultW or ALUResultM using ForwardB_E, with the same encoding as SrcA.
REQ-016 SrcB SHALL be Imm_Ext_E when ALUSrcE=1, else forwarded B.
REQ-017 ALU encoding:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt (signed, result 0 or 1)
  - all other codes give 0
REQ-018 All ALU arithmetic SHALL be modulo 2^32; overflow and carry SHALL be discarded.
REQ-019 ZeroE SHALL be 1 exactly when the ALU result is 0.
REQ-020 PCSrcE SHALL equal BranchE AND ZeroE.
REQ-021 PCTargetE SHALL equal PCE + Imm_Ext_E, modulo 2^32.
REQ-022 On every rising edge with rst=1, the block SHALL register the following, giving a latency of exactly one cycle:
  - ALU result into ALUResultM
  - forwarded B (not SrcB) into WriteDataM
  - RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E into their M outputs
REQ-023 Forwarding select 10 SHALL use the pre-edge value of ALUResultM, so that back-to-back dependent instructions chain correctly.
REQ-024 The block SHALL have no stall or enable input; the M register SHALL update every cycle.
REQ-025 A flush SHALL be implemented upstream by zeroing the E controls; a bubble SHALL produce RegWriteM=0 and MemWriteM=0 on the next cycle.

Reset
REQ-026 While rst=0, all M outputs SHALL be 0, and they SHALL go to 0 immediately, independent of clk.
REQ-027 Assertion of rst mid-operation SHALL discard the in-flight instruction; the first edge after release SHALL capture the current E inputs.
REQ-028 During reset, PCSrcE and PCTargetE SHALL stay combinational from the inputs, and ALUResultM forwarding SHALL supply 0.

Structure
REQ-029 Package riscv_pkg SHALL hold:
  - the ALU opcode constants
  - the forward-select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10)
REQ-030 The ALU SHALL be a sub-module named alu, with ports A, B, ALUControl, Result and Zero.
REQ-031 The forwarding muxes and the pipeline register SHALL remain in execute_cycle.

Verification
REQ-032 Add, immediate: RD1_E=5, Imm_Ext_E=7, ALUSrcE=1, ALUControlE=000 -> ALUResultM=12 after one edge.
REQ-033 Sub, register: RD1_E=3, RD2_E=5, ALUSrcE=0, ALUControlE=001 -> ALUResultM=0xFFFFFFFE; slt with RD1_E=0xFFFFFFFF, RD2_E=1 -> ALUResultM=1.
REQ-034 Forwarding chain: cycle 1 add gives 10; cycle 2 has ForwardA_E=10, Imm_Ext_E=4, ALUSrcE=1 -> ALUResultM=14. ForwardB_E=01 with ResultW=0xAA and MemWriteE=1 -> WriteDataM=0xAA.
REQ-035 Branch: BranchE=1, RD1_E=RD2_E=9, ALUControlE=001, PCE=0x100, Imm_Ext_E=0xFFFFFFF8 -> PCSrcE=1 and PCTargetE=0xF8 in the same cycle; RD2_E=8 -> PCSrcE=0.
REQ-036 Reset: assert rst=0 between edges with RegWriteM=1 -> all M outputs are 0 before the next edge; release rst -> the next edge captures the inputs.
REQ-037 Bubble: all E controls 0 -> RegWriteM=0 and MemWriteM=0 after one edge, with data fields passing through.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the execute stage: ALU opcodes and forwarding-select encodings.
package riscv_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Code 11 is unused by the hazard unit and falls back to the register-file operand.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, sub, and, or, signed slt; all other codes give zero.
module alu
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch decision and the E->M pipeline register.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [4:0]        RD_E,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [4:0]        RD_M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] alu_result;
  logic              zero_e;

  logic              reg_write_d,  reg_write_q;
  logic              mem_write_d,  mem_write_q;
  logic              result_src_d, result_src_q;
  logic [4:0]        rd_d,         rd_q;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic [DATA_W-1:0] write_data_d, write_data_q;
  logic [DATA_W-1:0] pc_plus4_d,   pc_plus4_q;

  // FWD_MEM uses the registered value, i.e. the result of the previous instruction.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase

    fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = RD2_E;
    endcase

    src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  end

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       (zero_e)
  );

  assign PCSrcE    = BranchE & zero_e;
  assign PCTargetE = PCE + Imm_Ext_E;

  // Stores take the forwarded register value, never the immediate.
  always_comb begin
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
    rd_d         = RD_E;
    alu_result_d = alu_result;
    write_data_d = fwd_b;
    pc_plus4_d   = PCPlus4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule
